// File: rtl/dcache_pkg.sv
// dcache_pkg: shared widths, tag-word layout and controller states for the 2-way data cache
package dcache_pkg;
   localparam int TAG_W     = 23;
   localparam int INDEX_W   = 4;
   localparam int OFFSET_W  = 5;
   localparam int LINE_W    = 256;
   localparam int TAGWORD_W = TAG_W + 2;
   localparam int VALID_BIT = 24;
   localparam int DIRTY_BIT = 23;
   typedef enum logic [2:0] {IDLE, MISS, WRITEBACK, READMISS, READMISSOK} state_e;
endpackage

// File: rtl/dcache_word_merge.sv
// dcache_word_merge: picks one 32-bit word of a cache line and builds the line with that word replaced
module dcache_word_merge
   import dcache_pkg::*;
(
   input  logic [LINE_W-1:0] line_i,
   input  logic [2:0]        sel_i,
   input  logic [31:0]       wdata_i,
   output logic [31:0]       rdata_o,
   output logic [LINE_W-1:0] line_o
);
   always_comb begin
      rdata_o = line_i[{sel_i, 5'b0} +: 32];
      line_o = line_i;
      line_o[{sel_i, 5'b0} +: 32] = wdata_i;
   end
endmodule

// File: rtl/dcache_controller.sv
// dcache_controller: hit/miss detection, pipeline stall and write-back/refill sequencing
// between the CPU MEM stage, the 2-way cache SRAM and a 256-bit line memory.
module dcache_controller
   import dcache_pkg::*;
(
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [31:0]          cpu_addr_i,
   input  logic [31:0]          cpu_data_i,
   input  logic                 cpu_MemRead_i,
   input  logic                 cpu_MemWrite_i,
   output logic [31:0]          cpu_data_o,
   output logic                 cpu_stall_o,
   output logic                 mem_enable_o,
   output logic                 mem_write_o,
   output logic [31:0]          mem_addr_o,
   output logic [LINE_W-1:0]    mem_data_o,
   input  logic [LINE_W-1:0]    mem_data_i,
   input  logic                 mem_ack_i,
   output logic [INDEX_W-1:0]   sram_addr_o,
   output logic [TAGWORD_W-1:0] sram_tag_o,
   output logic [LINE_W-1:0]    sram_data_o,
   output logic                 sram_enable_o,
   output logic                 sram_write_o,
   input  logic [TAGWORD_W-1:0] sram_tag_i,
   input  logic [LINE_W-1:0]    sram_data_i,
   input  logic                 sram_hit_i
);
   state_e              state_q, state_d;
   logic                mem_enable_q, mem_enable_d;
   logic                mem_write_q, mem_write_d;
   logic [31:0]         mem_addr_q, mem_addr_d;
   logic [LINE_W-1:0]   mem_data_q, mem_data_d;
   logic [LINE_W-1:0]   refill_q, refill_d;
   logic [TAG_W-1:0]    tag;
   logic [INDEX_W-1:0]  index;
   logic [31:0]         line_addr;
   logic                req, idle, victim_dirty, unused_ok;
   logic [LINE_W-1:0]   merged;
   assign tag          = cpu_addr_i[31 -: TAG_W];
   assign index        = cpu_addr_i[OFFSET_W +: INDEX_W];
   assign line_addr    = {tag, index, {OFFSET_W{1'b0}}};
   assign unused_ok    = ^cpu_addr_i[1:0];
   assign req          = cpu_MemRead_i | cpu_MemWrite_i;
   assign idle         = state_q == IDLE;
   assign victim_dirty = sram_tag_i[VALID_BIT] & sram_tag_i[DIRTY_BIT];
   dcache_word_merge u_merge (
      .line_i  (sram_data_i),
      .sel_i   (cpu_addr_i[4:2]),
      .wdata_i (cpu_data_i),
      .rdata_o (cpu_data_o),
      .line_o  (merged)
   );
   assign cpu_stall_o   = (idle & req & ~sram_hit_i) | ~idle;
   assign sram_addr_o   = index;
   assign sram_enable_o = req | ~idle;
   assign sram_write_o  = (idle & cpu_MemWrite_i & sram_hit_i) | (state_q == READMISSOK);
   assign sram_data_o   = idle ? merged : refill_q;
   // store hits mark the line dirty, refills install it clean
   assign sram_tag_o    = {1'b1, idle, tag};
   assign mem_enable_o  = mem_enable_q;
   assign mem_write_o   = mem_write_q;
   assign mem_addr_o    = mem_addr_q;
   assign mem_data_o    = mem_data_q;
   always_comb begin
      state_d      = state_q;
      mem_enable_d = mem_enable_q;
      mem_write_d  = mem_write_q;
      mem_addr_d   = mem_addr_q;
      mem_data_d   = mem_data_q;
      refill_d     = refill_q;
      case (state_q)
         IDLE: state_d = (req & ~sram_hit_i) ? MISS : IDLE;
         MISS: begin
            // victim tag/line are still on the SRAM outputs only in this cycle
            state_d      = victim_dirty ? WRITEBACK : READMISS;
            mem_enable_d = 1'b1;
            mem_write_d  = victim_dirty;
            mem_addr_d   = victim_dirty ? {sram_tag_i[TAG_W-1:0], index, {OFFSET_W{1'b0}}} : line_addr;
            mem_data_d   = sram_data_i;
         end
         WRITEBACK: if (mem_ack_i) begin
            state_d     = READMISS;
            mem_write_d = 1'b0;
            mem_addr_d  = line_addr;
         end
         READMISS: if (mem_ack_i) begin
            state_d      = READMISSOK;
            mem_enable_d = 1'b0;
            refill_d     = mem_data_i;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         mem_enable_q <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_addr_q   <= '0;
         mem_data_q   <= '0;
         refill_q     <= '0;
      end else begin
         state_q      <= state_d;
         mem_enable_q <= mem_enable_d;
         mem_write_q  <= mem_write_d;
         mem_addr_q   <= mem_addr_d;
         mem_data_q   <= mem_data_d;
         refill_q     <= refill_d;
      end
   end
endmodule

// File: tb/tb_dcache_controller.sv
// tb_dcache_controller: drives the controller against a 2-way SRAM model and a line memory,
// checking loads against a flat golden memory and stall lengths against miss/dirty predictions.
module tb_dcache_controller;
   logic         clk_i = 1'b0;
   logic         rst_i;
   logic [31:0]  cpu_addr_i, cpu_data_i, cpu_data_o, mem_addr_o;
   logic         cpu_MemRead_i, cpu_MemWrite_i, cpu_stall_o;
   logic         mem_enable_o, mem_write_o, mem_ack_i;
   logic [255:0] mem_data_o, mem_data_i, sram_data_o, sram_data_i;
   logic [3:0]   sram_addr_o;
   logic [24:0]  sram_tag_o, sram_tag_i;
   logic         sram_enable_o, sram_write_o, sram_hit_i;
   int n_tests = 0, n_fail = 0;
   always #5 clk_i = ~clk_i;
   dcache_controller dut (
      .clk_i(clk_i), .rst_i(rst_i), .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
      .cpu_MemRead_i(cpu_MemRead_i), .cpu_MemWrite_i(cpu_MemWrite_i), .cpu_data_o(cpu_data_o),
      .cpu_stall_o(cpu_stall_o), .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
      .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
      .sram_addr_o(sram_addr_o), .sram_tag_o(sram_tag_o), .sram_data_o(sram_data_o),
      .sram_enable_o(sram_enable_o), .sram_write_o(sram_write_o), .sram_tag_i(sram_tag_i),
      .sram_data_i(sram_data_i), .sram_hit_i(sram_hit_i)
   );
   task automatic chk(input string n, input logic [255:0] act, input logic [255:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", n, act, exp);
      end
   endtask
   function automatic logic [255:0] mk_line(input logic [31:0] a);
      logic [255:0] l;
      for (int k = 0; k < 8; k++) l[32*k +: 32] = ((a + 32'(4*k)) * 32'h9E3779B1) ^ 32'hA5A55A5A;
      return l;
   endfunction
   // golden flat memory (what every load must return) and the backing line memory
   logic [255:0] gold [logic [31:0]];
   logic [255:0] mline [logic [31:0]];
   function automatic logic [255:0] g_line(input logic [31:0] la);
      return gold.exists(la) ? gold[la] : mk_line(la);
   endfunction
   function automatic logic [255:0] mem_rd(input logic [31:0] la);
      return mline.exists(la) ? mline[la] : mk_line(la);
   endfunction
   function automatic logic [31:0] g_word(input logic [31:0] a);
      logic [255:0] l;
      l = g_line({a[31:5], 5'b0});
      return l[32*int'(a[4:2]) +: 32];
   endfunction
   // SRAM environment: 2 ways x 16 sets, LRU bit names the way to replace
   logic         use_model, m_clr, pre_go, pre_way, pre_lru;
   logic [3:0]   pre_idx;
   logic [24:0]  pre_tag, v_tag, m_tago;
   logic [255:0] pre_line, v_data, m_datao;
   logic         v_hit, m_h0, m_h1, m_hit, m_way;
   logic [24:0]  m_tag [2][16];
   logic [255:0] m_data [2][16];
   logic         m_lru [16];
   always_comb begin
      m_h0 = m_tag[0][sram_addr_o][24] && m_tag[0][sram_addr_o][22:0] == cpu_addr_i[31:9];
      m_h1 = m_tag[1][sram_addr_o][24] && m_tag[1][sram_addr_o][22:0] == cpu_addr_i[31:9];
      m_hit = m_h0 | m_h1;
      m_way = m_hit ? m_h1 : m_lru[sram_addr_o];
      m_tago = m_tag[m_way][sram_addr_o];
      m_datao = m_data[m_way][sram_addr_o];
   end
   assign sram_tag_i  = use_model ? m_tago : v_tag;
   assign sram_data_i = use_model ? m_datao : v_data;
   assign sram_hit_i  = use_model ? m_hit : v_hit;
   always @(posedge clk_i) begin
      if (m_clr) begin
         for (int w = 0; w < 2; w++)
            for (int s = 0; s < 16; s++) begin
               m_tag[w][s] <= '0;
               m_data[w][s] <= '0;
               m_lru[s] <= 1'b0;
            end
      end else if (pre_go) begin
         m_tag[pre_way][pre_idx] <= pre_tag;
         m_data[pre_way][pre_idx] <= pre_line;
         m_lru[pre_idx] <= pre_lru;
      end else if (use_model && sram_enable_o) begin
         if (sram_write_o) begin
            m_tag[m_way][sram_addr_o] <= sram_tag_o;
            m_data[m_way][sram_addr_o] <= sram_data_o;
            m_lru[sram_addr_o] <= ~m_way;
         end else if (m_hit) m_lru[sram_addr_o] <= ~m_way;
      end
   end
   task automatic preload(input logic w, input logic [3:0] idx, input logic [24:0] tw, input logic [255:0] l, input logic lru);
      @(negedge clk_i);
      pre_way = w; pre_idx = idx; pre_tag = tw; pre_line = l; pre_lru = lru; pre_go = 1'b1;
      @(posedge clk_i); #1;
      pre_go = 1'b0;
   endtask
   task automatic pred(input logic [31:0] a, output logic hit, output logic dirty);
      logic [3:0] s;
      logic v;
      s = a[8:5];
      hit = (m_tag[0][s][24] && m_tag[0][s][22:0] == a[31:9]) || (m_tag[1][s][24] && m_tag[1][s][22:0] == a[31:9]);
      v = m_lru[s];
      dirty = m_tag[v][s][24] && m_tag[v][s][23];
   endtask
   // memory responder: ack after lat extra cycles of a held request
   int lat = 1, cnt = 0;
   initial begin
      mem_ack_i = 1'b0;
      mem_data_i = '0;
      forever begin
         @(negedge clk_i);
         mem_ack_i = 1'b0;
         if (mem_enable_o && !rst_i) begin
            if (cnt >= lat) begin
               mem_ack_i = 1'b1;
               cnt = 0;
               if (mem_write_o) mline[mem_addr_o] = mem_data_o;
               else mem_data_i = mem_rd(mem_addr_o);
            end else cnt++;
         end else cnt = 0;
      end
   end
   // per-stalled-cycle trace of one access, plus the completing cycle
   logic         tr_en[$], tr_wr[$], tr_swr[$];
   logic [31:0]  tr_addr[$];
   logic [255:0] tr_data[$];
   logic [24:0]  tr_stag[$];
   logic         fin_swr;
   logic [24:0]  fin_stag;
   logic [255:0] fin_sdata;
   task automatic access(input logic [31:0] a, input logic [31:0] d, input logic w, output int cyc, output logic [31:0] rd);
      logic [255:0] l;
      @(posedge clk_i); #1;
      cpu_addr_i = a; cpu_data_i = d; cpu_MemRead_i = ~w; cpu_MemWrite_i = w;
      cyc = 0;
      tr_en.delete(); tr_wr.delete(); tr_swr.delete(); tr_addr.delete(); tr_data.delete(); tr_stag.delete();
      forever begin
         @(negedge clk_i);
         if (!cpu_stall_o) break;
         tr_en.push_back(mem_enable_o); tr_wr.push_back(mem_write_o); tr_addr.push_back(mem_addr_o);
         tr_data.push_back(mem_data_o); tr_swr.push_back(sram_write_o); tr_stag.push_back(sram_tag_o);
         cyc++;
         if (cyc > 400) begin
            n_tests++; n_fail++;
            $display("FAIL timeout: stall still 1 after %0d cycles, want 0", cyc);
            break;
         end
      end
      rd = cpu_data_o; fin_swr = sram_write_o; fin_stag = sram_tag_o; fin_sdata = sram_data_o;
      if (w) begin
         l = g_line({a[31:5], 5'b0});
         l[32*int'(a[4:2]) +: 32] = d;
         gold[{a[31:5], 5'b0}] = l;
      end
      @(posedge clk_i); #1;
      cpu_MemRead_i = 1'b0; cpu_MemWrite_i = 1'b0;
   endtask
   typedef struct {
      logic rd, wr, hit;
      logic [31:0] addr, wdata, e_data;
      logic [24:0] tag, e_tag;
      logic [255:0] line, e_sdata;
      logic e_stall, e_sen, e_swr;
   } vec_t;
   function automatic vec_t mkv(input logic rd, wr, input logic [31:0] a, d, input logic hit, e_stall, e_sen, e_swr);
      vec_t v;
      v.rd = rd; v.wr = wr; v.addr = a; v.wdata = d; v.hit = hit;
      v.tag = {2'b10, a[31:9]};
      v.line = mk_line(a ^ 32'h0000_0777);
      v.e_data = v.line[32*int'(a[4:2]) +: 32];
      v.e_sdata = v.line;
      v.e_sdata[32*int'(a[4:2]) +: 32] = d;
      v.e_tag = {2'b11, a[31:9]};
      v.e_stall = e_stall; v.e_sen = e_sen; v.e_swr = e_swr;
      return v;
   endfunction
   vec_t vt[8];
   initial begin
      int cyc, exp_cyc;
      logic [31:0] rd, a, d, ev;
      logic [255:0] l, vl;
      logic w, h, dty;
      rst_i = 1'b1; use_model = 1'b0; m_clr = 1'b0; pre_go = 1'b0;
      cpu_addr_i = '0; cpu_data_i = '0; cpu_MemRead_i = 1'b0; cpu_MemWrite_i = 1'b0;
      v_tag = '0; v_data = '0; v_hit = 1'b0;
      pre_way = 1'b0; pre_idx = '0; pre_tag = '0; pre_line = '0; pre_lru = 1'b0;
      repeat (2) @(negedge clk_i);
      chk("reset.mem_enable", mem_enable_o, 0);
      chk("reset.mem_write", mem_write_o, 0);
      chk("reset.mem_addr", mem_addr_o, 0);
      chk("reset.mem_data", mem_data_o, 0);
      chk("reset.stall", cpu_stall_o, 0);
      chk("reset.sram_enable", sram_enable_o, 0);
      #1 rst_i = 1'b0;
      vt[0] = mkv(0, 0, 32'h0000_1234, 32'h0, 0, 0, 0, 0);
      vt[1] = mkv(1, 0, 32'h0000_0100, 32'h0, 1, 0, 1, 0);
      vt[2] = mkv(1, 0, 32'h0ABC_DE1C, 32'h0, 1, 0, 1, 0);
      vt[3] = mkv(0, 1, 32'h0000_004C, 32'hCAFE_F00D, 1, 0, 1, 1);
      vt[4] = mkv(1, 1, 32'h1234_5674, 32'h0BAD_C0DE, 1, 0, 1, 1);
      vt[5] = mkv(1, 0, 32'h0000_0200, 32'h0, 0, 1, 1, 0);
      vt[6] = mkv(0, 1, 32'hFFFF_FFE0, 32'h1, 0, 1, 1, 0);
      vt[7] = mkv(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 1, 0, 1, 1);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk_i); #1;
         cpu_MemRead_i = vt[i].rd; cpu_MemWrite_i = vt[i].wr; cpu_addr_i = vt[i].addr; cpu_data_i = vt[i].wdata;
         v_hit = vt[i].hit; v_tag = vt[i].tag; v_data = vt[i].line;
         #1;
         if (vt[i].rd && !vt[i].wr && vt[i].hit) chk($sformatf("vec%0d.data", i), cpu_data_o, vt[i].e_data);
         chk($sformatf("vec%0d.stall", i), cpu_stall_o, vt[i].e_stall);
         chk($sformatf("vec%0d.sram_enable", i), sram_enable_o, vt[i].e_sen);
         chk($sformatf("vec%0d.sram_write", i), sram_write_o, vt[i].e_swr);
         chk($sformatf("vec%0d.sram_addr", i), sram_addr_o, vt[i].addr[8:5]);
         if (vt[i].e_swr) begin
            chk($sformatf("vec%0d.sram_tag", i), sram_tag_o, vt[i].e_tag);
            chk($sformatf("vec%0d.sram_data", i), sram_data_o, vt[i].e_sdata);
         end
         rst_i = 1'b1; #1;
         cpu_MemRead_i = 1'b0; cpu_MemWrite_i = 1'b0; rst_i = 1'b0;
      end
      use_model = 1'b1;
      @(negedge clk_i); m_clr = 1'b1;
      @(posedge clk_i); #1 m_clr = 1'b0;
      // cold read miss
      l = mk_line(32'h120); l[63:32] = 32'hDEAD_BEEF; mline[32'h120] = l; gold[32'h120] = l;
      lat = 1;
      access(32'h0000_0124, 32'h0, 1'b0, cyc, rd);
      chk("cold.stall_cycles", cyc, 5);
      if (tr_en.size() >= 5) begin
         chk("cold.miss_no_enable", tr_en[1], 0);
         chk("cold.rm_enable", tr_en[2], 1);
         chk("cold.rm_write", tr_wr[2], 0);
         chk("cold.rm_addr", tr_addr[2], 32'h0000_0120);
         chk("cold.fill_write", tr_swr[4], 1);
         chk("cold.fill_tag", tr_stag[4], 25'h100_0000);
      end
      chk("cold.load", rd, 32'hDEAD_BEEF);
      // write hit on the resident line
      access(32'h0000_0128, 32'h1234_5678, 1'b1, cyc, rd);
      chk("wh.stall_cycles", cyc, 0);
      chk("wh.sram_write", fin_swr, 1);
      chk("wh.dirty", fin_stag[23], 1);
      chk("wh.tag", fin_stag, 25'h180_0000);
      chk("wh.line", fin_sdata, g_line(32'h120));
      // idle and spurious ack
      @(negedge clk_i);
      chk("idle.sram_enable", sram_enable_o, 0);
      chk("idle.stall", cpu_stall_o, 0);
      #1 mem_ack_i = 1'b1;
      @(negedge clk_i);
      chk("spur.stall", cpu_stall_o, 0);
      chk("spur.mem_enable", mem_enable_o, 0);
      chk("spur.sram_enable", sram_enable_o, 0);
      access(32'h0000_012C, 32'h0, 1'b0, cyc, rd);
      chk("spur.hit_cycles", cyc, 0);
      chk("spur.hit_load", rd, g_word(32'h12C));
      access(32'h0000_0128, 32'h0, 1'b0, cyc, rd);
      chk("wh.readback", rd, 32'h1234_5678);
      // dirty eviction in set 1
      vl = mk_line(32'h1111_0000);
      gold[32'hA20] = vl;
      preload(1'b0, 4'd1, {2'b11, 23'd5}, vl, 1'b0);
      preload(1'b1, 4'd1, {2'b10, 23'd6}, mk_line(32'hC20), 1'b0);
      lat = 2;
      access(32'h0000_0E24, 32'h0, 1'b0, cyc, rd);
      chk("dirty.stall_cycles", cyc, 9);
      if (tr_en.size() >= 9) begin
         chk("dirty.wb_enable", tr_en[2], 1);
         chk("dirty.wb_write", tr_wr[2], 1);
         chk("dirty.wb_addr", tr_addr[2], 32'h0000_0A20);
         chk("dirty.wb_data", tr_data[2], vl);
         chk("dirty.wb_hold_addr", tr_addr[4], 32'h0000_0A20);
         chk("dirty.rm_enable", tr_en[5], 1);
         chk("dirty.rm_write", tr_wr[5], 0);
         chk("dirty.rm_addr", tr_addr[5], 32'h0000_0E20);
         chk("dirty.fill_tag", tr_stag[8], {2'b10, 23'd7});
      end
      chk("dirty.load", rd, g_word(32'hE24));
      chk("dirty.mem_written", mem_rd(32'hA20), vl);
      // late ack: refill held for 10 cycles
      lat = 9;
      access(32'h0000_0644, 32'h0, 1'b0, cyc, rd);
      chk("late.stall_cycles", cyc, 13);
      if (tr_en.size() >= 13)
         for (int i = 2; i < 12; i++) begin
            chk($sformatf("late.enable%0d", i), tr_en[i], 1);
            chk($sformatf("late.addr%0d", i), tr_addr[i], 32'h0000_0640);
            chk($sformatf("late.data%0d", i), tr_data[i], 0);
         end
      chk("late.load", rd, g_word(32'h644));
      // reset in the middle of a refill
      lat = 20;
      @(posedge clk_i); #1;
      cpu_addr_i = 32'h0000_0864; cpu_MemRead_i = 1'b1;
      repeat (3) @(negedge clk_i);
      chk("rst.pre_enable", mem_enable_o, 1);
      #1 rst_i = 1'b1;
      #1;
      chk("rst.mem_enable", mem_enable_o, 0);
      chk("rst.mem_write", mem_write_o, 0);
      chk("rst.mem_addr", mem_addr_o, 0);
      cpu_MemRead_i = 1'b0;
      #1;
      chk("rst.idle_sram_enable", sram_enable_o, 0);
      chk("rst.idle_stall", cpu_stall_o, 0);
      rst_i = 1'b0;
      lat = 1;
      access(32'h0000_0864, 32'h0, 1'b0, cyc, rd);
      chk("rst.restart_cycles", cyc, 5);
      chk("rst.restart_load", rd, g_word(32'h864));
      // random traffic over a small conflict-heavy region
      for (int i = 0; i < 200; i++) begin
         a = (32'($urandom_range(0, 5)) << 9) | (32'($urandom_range(0, 3)) << 5) | (32'($urandom_range(0, 7)) << 2);
         w = 1'($urandom_range(0, 1));
         d = $urandom;
         lat = $urandom_range(0, 3);
         pred(a, h, dty);
         exp_cyc = h ? 0 : (dty ? 3 + 2 * (lat + 1) : 3 + (lat + 1));
         ev = g_word(a);
         access(a, d, w, cyc, rd);
         chk($sformatf("rnd%0d.cycles", i), cyc, exp_cyc);
         if (!w) chk($sformatf("rnd%0d.load", i), rd, ev);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
